// File: rtl/aer_event_packer_pkg.sv
// Shared word-type codes, arbiter select encoding and the default event-word layout
// for the AER event packer.
package aer_event_packer_pkg;

   // Word type lives in the top two bits of every FIFO word
   localparam logic [1:0] AER_WT_EVT  = 2'b00;
   localparam logic [1:0] AER_WT_WRAP = 2'b01;
   localparam logic [1:0] AER_WT_DROP = 2'b10;

   // What the holding register loads on a free slot, in priority order
   typedef enum logic [1:0] {
      SelNone,
      SelWrap,
      SelDrop,
      SelEvt
   } aer_sel_e;

   // Event word for the default geometry (64-bit word, 10-bit x/y, 32-bit ts).
   // The top level packs by slicing so that other geometries work too.
   typedef struct packed {
      logic [1:0]  wtype;
      logic        pol;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [8:0]  pad;
      logic [31:0] ts;
   } aer_evt_word_t;

endpackage

// File: rtl/aer_event_packer_ts_counter.sv
// Free-running prescaled timestamp with a wrap counter. Emits a combinational
// one-cycle pulse in the cycle whose tick takes ts from all-ones back to zero.
module aer_event_packer_ts_counter #(
   parameter int unsigned TSW    = 32,
   parameter int unsigned TS_DIV = 1,
   parameter int unsigned WRW    = 16
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_en,
   output logic [TSW-1:0] o_ts,
   output logic [WRW-1:0] o_wrap_cnt,
   output logic           o_wrap
);

   localparam int unsigned PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(TS_DIV - 1);

   logic [PW-1:0]  r_ps;
   logic [TSW-1:0] r_ts;
   logic [WRW-1:0] r_wrap_cnt;
   logic           w_tick;
   logic           w_wrap;

   // Terminal count of the prescaler advances the timestamp
   always_comb begin
      w_tick = i_en && (r_ps == PS_LAST);
      w_wrap = w_tick && (r_ts == '1);
   end

   // Prescaler, timestamp and wrap counter; everything freezes while disabled
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ps       <= '0;
         r_ts       <= '0;
         r_wrap_cnt <= '0;
      end else if (i_en) begin
         r_ps <= w_tick ? '0 : r_ps + 1'b1;
         if (w_tick) begin
            r_ts <= r_ts + 1'b1;
         end
         if (w_wrap) begin
            r_wrap_cnt <= r_wrap_cnt + 1'b1;
         end
      end
   end

   assign o_ts       = r_ts;
   assign o_wrap_cnt = r_wrap_cnt;
   assign o_wrap     = w_wrap;

endmodule

// File: rtl/aer_event_packer.sv
// Packs decoded AER events into timestamped FIFO words behind a single holding
// register, inserting WRAP markers on timestamp rollover and DROP markers that
// report events discarded while the FIFO was full.
module aer_event_packer
   import aer_event_packer_pkg::*;
#(
   parameter int unsigned DWIDTH = 64,
   parameter int unsigned XW     = 10,
   parameter int unsigned YW     = 10,
   parameter int unsigned TSW    = 32,
   parameter int unsigned TS_DIV = 1,
   parameter int unsigned WRW    = 16,
   parameter int unsigned DROPW  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic              i_cfg_drop_en,
   input  logic              i_evt_valid,
   output logic              o_evt_ready,
   input  logic [XW-1:0]     i_evt_x,
   input  logic [YW-1:0]     i_evt_y,
   input  logic              i_evt_pol,
   input  logic              i_fifo_full,
   output logic              o_fifo_wr_en,
   output logic [DWIDTH-1:0] o_fifo_wdata,
   output logic [DROPW-1:0]  o_drop_cnt
);

   // Elaboration-time geometry checks
   if (3 + XW + YW + TSW > DWIDTH) begin : g_bad_evt_geom
      $error("event fields do not fit in DWIDTH");
   end
   if (WRW + 2 > DWIDTH) begin : g_bad_wrap_geom
      $error("wrap counter does not fit in DWIDTH");
   end
   if (DROPW + 2 > DWIDTH) begin : g_bad_drop_geom
      $error("drop counter does not fit in DWIDTH");
   end
   if (TS_DIV < 1) begin : g_bad_div
      $error("TS_DIV must be at least 1");
   end

   logic              w_rst;
   logic [TSW-1:0]    w_ts;
   logic [WRW-1:0]    w_wrap_cnt;
   logic              w_wrap;

   logic              r_hold_valid;
   logic [DWIDTH-1:0] r_hold_data;
   logic              r_wrap_pend;
   logic [DROPW-1:0]  r_drop_cnt;

   logic              w_wr_en;
   logic              w_slot_free;
   logic              w_drop_nz;
   logic              w_ready;
   logic              w_accept;
   logic              w_drop_evt;
   aer_sel_e          w_sel;

   logic [DWIDTH-1:0] w_evt_word;
   logic [DWIDTH-1:0] w_wrap_word;
   logic [DWIDTH-1:0] w_drop_word;

   logic              w_hold_valid_nxt;
   logic [DWIDTH-1:0] w_hold_data_nxt;
   logic              w_wrap_pend_nxt;
   logic [DROPW-1:0]  w_drop_cnt_nxt;

   assign w_rst = i_rst | i_clr;

   aer_event_packer_ts_counter #(
      .TSW    (TSW),
      .TS_DIV (TS_DIV),
      .WRW    (WRW)
   ) u_ts_counter (
      .i_clk      (i_clk),
      .i_rst      (w_rst),
      .i_en       (i_en),
      .o_ts       (w_ts),
      .o_wrap_cnt (w_wrap_cnt),
      .o_wrap     (w_wrap)
   );

   // Handshakes: write whenever the FIFO can take the held word; a reset cycle
   // suppresses both the write and event acceptance so the held word is lost
   always_comb begin
      w_wr_en     = r_hold_valid && !i_fifo_full && !w_rst;
      w_slot_free = !r_hold_valid || w_wr_en;
      w_drop_nz   = (r_drop_cnt != '0);
      if (w_rst) begin
         w_ready = 1'b0;
      end else if (i_cfg_drop_en) begin
         w_ready = i_en;
      end else begin
         w_ready = i_en && w_slot_free && !r_wrap_pend && !w_drop_nz;
      end
      w_accept = i_evt_valid && w_ready;
   end

   // Arbiter: markers take the free slot ahead of a new event
   always_comb begin
      w_sel = SelNone;
      if (w_slot_free && !w_rst) begin
         if (r_wrap_pend) begin
            w_sel = SelWrap;
         end else if (w_drop_nz) begin
            w_sel = SelDrop;
         end else if (w_accept) begin
            w_sel = SelEvt;
         end
      end
      // Only reachable in drop mode: accepted but the slot went to someone else
      w_drop_evt = w_accept && (w_sel != SelEvt);
   end

   // Word formatting for the three word types
   always_comb begin
      w_evt_word                         = '0;
      w_evt_word[DWIDTH-1 -: 2]          = AER_WT_EVT;
      w_evt_word[DWIDTH-3]               = i_evt_pol;
      w_evt_word[DWIDTH-4 -: XW]         = i_evt_x;
      w_evt_word[DWIDTH-4-XW -: YW]      = i_evt_y;
      w_evt_word[TSW-1:0]                = w_ts;
      w_wrap_word                        = '0;
      w_wrap_word[DWIDTH-1 -: 2]         = AER_WT_WRAP;
      w_wrap_word[WRW-1:0]               = w_wrap_cnt;
      w_drop_word                        = '0;
      w_drop_word[DWIDTH-1 -: 2]         = AER_WT_DROP;
      w_drop_word[DROPW-1:0]             = r_drop_cnt;
   end

   // Next state of the holding register
   always_comb begin
      w_hold_valid_nxt = r_hold_valid;
      w_hold_data_nxt  = r_hold_data;
      if (w_wr_en) begin
         w_hold_valid_nxt = 1'b0;
      end
      unique case (w_sel)
         SelWrap: begin
            w_hold_valid_nxt = 1'b1;
            w_hold_data_nxt  = w_wrap_word;
         end
         SelDrop: begin
            w_hold_valid_nxt = 1'b1;
            w_hold_data_nxt  = w_drop_word;
         end
         SelEvt: begin
            w_hold_valid_nxt = 1'b1;
            w_hold_data_nxt  = w_evt_word;
         end
         default: ;
      endcase
   end

   // Next state of the marker bookkeeping; a new wrap beats clearing the old one
   always_comb begin
      w_wrap_pend_nxt = r_wrap_pend;
      if (w_wrap) begin
         w_wrap_pend_nxt = 1'b1;
      end else if (w_sel == SelWrap) begin
         w_wrap_pend_nxt = 1'b0;
      end

      w_drop_cnt_nxt = r_drop_cnt;
      if (w_sel == SelDrop) begin
         w_drop_cnt_nxt = w_drop_evt ? DROPW'(1) : '0;
      end else if (w_drop_evt && (r_drop_cnt != '1)) begin
         w_drop_cnt_nxt = r_drop_cnt + 1'b1;
      end
   end

   // State registers for hold stage, wrap marker and drop counter
   always_ff @(posedge i_clk) begin
      if (w_rst) begin
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
         r_wrap_pend  <= 1'b0;
         r_drop_cnt   <= '0;
      end else begin
         r_hold_valid <= w_hold_valid_nxt;
         r_hold_data  <= w_hold_data_nxt;
         r_wrap_pend  <= w_wrap_pend_nxt;
         r_drop_cnt   <= w_drop_cnt_nxt;
      end
   end

   assign o_evt_ready  = w_ready;
   assign o_fifo_wr_en = w_wr_en;
   assign o_fifo_wdata = r_hold_data;
   assign o_drop_cnt   = r_drop_cnt;

endmodule
